// File: rtl/alu_unit.sv
// 16-bit integer ALU: combinational result path plus registered status flags
// (c, l, f, z, n) that feed carry-in and condition evaluation.
module alu_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] dst,
    input  logic [WIDTH-1:0] src,
    input  logic [3:0]       oper,
    input  logic [3:0]       func,
    input  logic [3:0]       cond,
    input  logic             sign_ext_imm,
    output logic [WIDTH-1:0] result,
    output logic             c,
    output logic             l,
    output logic             f,
    output logic             z,
    output logic             n
);

    localparam int MSB = WIDTH - 1;

    // Primary opcodes
    localparam logic [3:0] OP_RR    = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_XORI  = 4'b0011;
    localparam logic [3:0] OP_SPEC  = 4'b0100;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_ADDUI = 4'b0110;
    localparam logic [3:0] OP_ADDCI = 4'b0111;
    localparam logic [3:0] OP_SHIFT = 4'b1000;
    localparam logic [3:0] OP_SUBI  = 4'b1001;
    localparam logic [3:0] OP_SUBCI = 4'b1010;
    localparam logic [3:0] OP_CMPI  = 4'b1011;
    localparam logic [3:0] OP_BCOND = 4'b1100;
    localparam logic [3:0] OP_MOVI  = 4'b1101;
    localparam logic [3:0] OP_MULI  = 4'b1110;
    localparam logic [3:0] OP_LUI   = 4'b1111;

    // Extended opcodes for OP_RR
    localparam logic [3:0] FN_AND  = 4'b0001;
    localparam logic [3:0] FN_OR   = 4'b0010;
    localparam logic [3:0] FN_XOR  = 4'b0011;
    localparam logic [3:0] FN_NOT  = 4'b0100;
    localparam logic [3:0] FN_ADD  = 4'b0101;
    localparam logic [3:0] FN_ADDU = 4'b0110;
    localparam logic [3:0] FN_ADDC = 4'b0111;
    localparam logic [3:0] FN_SUB  = 4'b1001;
    localparam logic [3:0] FN_SUBC = 4'b1010;
    localparam logic [3:0] FN_CMP  = 4'b1011;
    localparam logic [3:0] FN_MOV  = 4'b1101;
    localparam logic [3:0] FN_MUL  = 4'b1110;
    localparam logic [3:0] FN_AND2 = 4'b1111;

    // Extended opcodes for OP_SPEC
    localparam logic [3:0] FN_PASS  = 4'b1000;
    localparam logic [3:0] FN_JCOND = 4'b1100;
    localparam logic [3:0] FN_SCOND = 4'b1101;

    // Extended opcodes for OP_SHIFT
    localparam logic [3:0] FN_SLL  = 4'b0000;
    localparam logic [3:0] FN_SRL  = 4'b0001;
    localparam logic [3:0] FN_SAL  = 4'b0010;
    localparam logic [3:0] FN_SAR  = 4'b0011;
    localparam logic [3:0] FN_LSH  = 4'b0100;
    localparam logic [3:0] FN_ASHU = 4'b0110;

    function automatic logic cond_true(input logic [3:0] sel, input logic fc, input logic fl,
                                       input logic ff, input logic fz, input logic fn);
        case (sel)
            4'd0:    cond_true = fz;
            4'd1:    cond_true = !fz;
            4'd2:    cond_true = fc;
            4'd3:    cond_true = !fc;
            4'd4:    cond_true = fl;
            4'd5:    cond_true = !fl;
            4'd6:    cond_true = fn;
            4'd7:    cond_true = !fn;
            4'd8:    cond_true = ff;
            4'd9:    cond_true = !ff;
            4'd10:   cond_true = !fl && !fz;
            4'd11:   cond_true = fl || fz;
            4'd12:   cond_true = !fn && !fz;
            4'd13:   cond_true = fn || fz;
            4'd14:   cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    endfunction

    logic             is_reg_form;
    logic [WIDTH-1:0] s_op;
    logic             uses_carry;
    logic             sets_add_flags;
    logic             sets_sub_flags;
    logic             sets_cmp_flags;
    logic             t_cond;

    assign is_reg_form = (oper == OP_RR) || (oper == OP_SPEC) || (oper == OP_SHIFT);
    assign s_op = (!is_reg_form && sign_ext_imm) ? {{(WIDTH-8){src[7]}}, src[7:0]} : src;

    assign uses_carry = (oper == OP_RR && (func == FN_ADDC || func == FN_SUBC))
                     || oper == OP_ADDCI || oper == OP_SUBCI;
    assign sets_add_flags = (oper == OP_RR && (func == FN_ADD || func == FN_ADDC))
                         || oper == OP_ADDI || oper == OP_ADDCI;
    assign sets_sub_flags = (oper == OP_RR && (func == FN_SUB || func == FN_SUBC))
                         || oper == OP_SUBI || oper == OP_SUBCI;
    assign sets_cmp_flags = (oper == OP_RR && func == FN_CMP) || oper == OP_CMPI;

    assign t_cond = cond_true(cond, c, l, f, z, n);

    // One 17-bit adder and subtractor serve every add/sub/cmp variant; bit 16 is carry/borrow.
    logic [WIDTH:0]   carry_in;
    logic [WIDTH:0]   sum_x;
    logic [WIDTH:0]   diff_x;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic [WIDTH-1:0] mul_lo;

    assign carry_in = {{WIDTH{1'b0}}, uses_carry & c};
    assign sum_x    = {1'b0, dst} + {1'b0, s_op} + carry_in;
    assign diff_x   = {1'b0, dst} - {1'b0, s_op} - carry_in;
    assign sum      = sum_x[WIDTH-1:0];
    assign diff     = diff_x[WIDTH-1:0];
    assign add_ovf  = (dst[MSB] == s_op[MSB]) && (sum[MSB] != dst[MSB]);
    assign sub_ovf  = (dst[MSB] != s_op[MSB]) && (diff[MSB] != dst[MSB]);
    assign mul_lo   = dst * s_op;

    // Right shifts use the two's-complement of the 5-bit count; any count >= 16 saturates.
    logic [4:0]       rcount;
    logic [WIDTH-1:0] sll_val;
    logic [WIDTH-1:0] srl_val;
    logic [WIDTH-1:0] sar_val;

    assign rcount  = 5'd0 - src[4:0];
    assign sll_val = dst << src[3:0];
    assign srl_val = rcount[4] ? '0 : (dst >> rcount[3:0]);
    assign sar_val = rcount[4] ? {WIDTH{dst[MSB]}} : WIDTH'($signed(dst) >>> rcount[3:0]);

    // NOTE: result gets a default before the case so no path through the block can infer a latch.
    always_comb begin
        result = '0;
        case (oper)
            OP_RR: begin
                case (func)
                    FN_ADD, FN_ADDU, FN_ADDC: result = sum;
                    FN_SUB, FN_SUBC, FN_CMP:  result = diff;
                    FN_MUL:                   result = mul_lo;
                    FN_AND, FN_AND2:          result = dst & s_op;
                    FN_OR:                    result = dst | s_op;
                    FN_XOR:                   result = dst ^ s_op;
                    FN_NOT:                   result = ~dst;
                    FN_MOV:                   result = s_op;
                    default:                  result = '0;
                endcase
            end
            OP_ANDI:                       result = dst & s_op;
            OP_ORI:                        result = dst | s_op;
            OP_XORI:                       result = dst ^ s_op;
            OP_ADDI, OP_ADDUI, OP_ADDCI:   result = sum;
            OP_SUBI, OP_SUBCI, OP_CMPI:    result = diff;
            OP_MOVI:                       result = s_op;
            OP_MULI:                       result = mul_lo;
            OP_LUI:                        result = {dst[7:0], src[7:0]};
            OP_BCOND:                      result = t_cond ? sum : dst;
            OP_SPEC: begin
                case (func)
                    FN_PASS:  result = src;
                    FN_SCOND: result = {{(WIDTH-1){1'b0}}, t_cond};
                    FN_JCOND: result = t_cond ? src : dst;
                    default:  result = '0;
                endcase
            end
            OP_SHIFT: begin
                case (func)
                    FN_SLL, FN_SAL: result = sll_val;
                    FN_SRL:         result = srl_val;
                    FN_SAR:         result = sar_val;
                    FN_LSH:         result = src[4] ? srl_val : sll_val;
                    FN_ASHU:        result = src[4] ? sar_val : sll_val;
                    default:        result = '0;
                endcase
            end
            default: result = '0;
        endcase
    end

    // NOTE: flags are state, so they are written with non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c <= 1'b0;
            l <= 1'b0;
            f <= 1'b0;
            z <= 1'b0;
            n <= 1'b0;
        end else if (sets_add_flags) begin
            c <= sum_x[WIDTH];
            f <= add_ovf;
        end else if (sets_sub_flags) begin
            c <= diff_x[WIDTH];
            f <= sub_ovf;
        end else if (sets_cmp_flags) begin
            z <= (dst == s_op);
            l <= diff_x[WIDTH];
            n <= ($signed(dst) < $signed(s_op));
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// Directed bench for alu_unit: expected results queued at drive time and
// popped when the combinational result settles; flags checked after each edge.
module tb_alu_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] dst, src;
    logic [3:0]  oper, func, cond;
    logic        sign_ext_imm;
    logic [15:0] result;
    logic        c, l, f, z, n;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];

    alu_unit #(.WIDTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .dst          (dst),
        .src          (src),
        .oper         (oper),
        .func         (func),
        .cond         (cond),
        .sign_ext_imm (sign_ext_imm),
        .result       (result),
        .c            (c),
        .l            (l),
        .f            (f),
        .z            (z),
        .n            (n)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one instruction at the falling edge, queue its expected result, compare after settling.
    task automatic step(input string tag, input logic [3:0] op, input logic [3:0] fn,
                        input logic [3:0] cd, input logic [15:0] d, input logic [15:0] s,
                        input logic sx, input logic [15:0] exp);
        exp_t e;
        @(negedge clk);
        oper = op; func = fn; cond = cd; dst = d; src = s; sign_ext_imm = sx;
        sb.push_back('{tag, exp});
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: observed empty scoreboard required one entry", tag);
        end else begin
            e = sb.pop_front();
            check(e.tag, result, e.exp);
        end
    endtask

    // Expected flags given as {c,l,f,z,n}, checked just after the next rising edge.
    task automatic flags_after(input string tag, input logic [4:0] exp);
        @(posedge clk);
        #1;
        check(tag, {11'b0, c, l, f, z, n}, {11'b0, exp});
    endtask

    initial begin
        reset = 1'b1;
        oper = 4'h0; func = 4'h0; cond = 4'h0;
        dst = 16'h0; src = 16'h0; sign_ext_imm = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_flags", {11'b0, c, l, f, z, n}, 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        // add / carry chain
        step("add_wrap", 4'b0000, 4'b0101, 4'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000);
        flags_after("add_flags", 5'b10000);
        step("addc", 4'b0000, 4'b0111, 4'd0, 16'h0001, 16'h0001, 1'b0, 16'h0003);
        flags_after("addc_flags", 5'b00000);
        step("add_ovf", 4'b0000, 4'b0101, 4'd0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000);
        flags_after("add_ovf_flags", 5'b00100);
        step("sub_borrow", 4'b0000, 4'b1001, 4'd0, 16'h0000, 16'h0001, 1'b0, 16'hFFFF);
        flags_after("sub_flags", 5'b10000);
        step("subc", 4'b0000, 4'b1010, 4'd0, 16'h0005, 16'h0002, 1'b0, 16'h0002);
        flags_after("subc_flags", 5'b00000);

        // compare and branch
        step("cmpi", 4'b1011, 4'h0, 4'd0, 16'h0005, 16'h0007, 1'b0, 16'hFFFE);
        flags_after("cmpi_flags", 5'b01001);
        step("bcond_l", 4'b1100, 4'h0, 4'd4, 16'h0100, 16'h0010, 1'b0, 16'h0110);
        step("bcond_nl", 4'b1100, 4'h0, 4'd5, 16'h0100, 16'h0010, 1'b0, 16'h0100);
        step("bcond_hi", 4'b1100, 4'h0, 4'd10, 16'h0100, 16'h0010, 1'b0, 16'h0100);
        step("bcond_ls", 4'b1100, 4'h0, 4'd11, 16'h0100, 16'h0010, 1'b0, 16'h0110);

        // shifts, including saturating right counts
        step("sar_1", 4'b1000, 4'b0011, 4'd0, 16'h8000, 16'h001F, 1'b0, 16'hC000);
        step("srl_1", 4'b1000, 4'b0001, 4'd0, 16'h8000, 16'h001F, 1'b0, 16'h4000);
        step("sll_4", 4'b1000, 4'b0000, 4'd0, 16'h0001, 16'h0004, 1'b0, 16'h0010);
        step("sar_16", 4'b1000, 4'b0011, 4'd0, 16'h8000, 16'h0010, 1'b0, 16'hFFFF);
        step("srl_16", 4'b1000, 4'b0001, 4'd0, 16'h8000, 16'h0010, 1'b0, 16'h0000);
        step("lsh_left", 4'b1000, 4'b0100, 4'd0, 16'h0001, 16'h0003, 1'b0, 16'h0008);
        step("lsh_right", 4'b1000, 4'b0100, 4'd0, 16'h8000, 16'h001E, 1'b0, 16'h2000);
        step("ashu_right", 4'b1000, 4'b0110, 4'd0, 16'h8000, 16'h001F, 1'b0, 16'hC000);
        step("shift_bad", 4'b1000, 4'b0111, 4'd0, 16'h8000, 16'h0001, 1'b0, 16'h0000);
        flags_after("shift_no_flags", 5'b01001);

        // immediates
        step("addi_sext", 4'b0101, 4'h0, 4'd0, 16'h0010, 16'h00FF, 1'b1, 16'h000F);
        flags_after("addi_sext_flags", 5'b11001);
        step("addi_zext", 4'b0101, 4'h0, 4'd0, 16'h0010, 16'h00FF, 1'b0, 16'h010F);
        flags_after("addi_zext_flags", 5'b01001);
        step("addu", 4'b0000, 4'b0110, 4'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000);
        flags_after("addu_no_flags", 5'b01001);
        step("lui", 4'b1111, 4'h0, 4'd0, 16'h12AB, 16'h0034, 1'b0, 16'hAB34);
        step("muli", 4'b1110, 4'h0, 4'd0, 16'h0100, 16'h0100, 1'b0, 16'h0000);
        step("mul", 4'b0000, 4'b1110, 4'd0, 16'h0003, 16'h0005, 1'b0, 16'h000F);
        step("not", 4'b0000, 4'b0100, 4'd0, 16'h00FF, 16'h0000, 1'b0, 16'hFF00);
        step("rr_bad", 4'b0000, 4'b0000, 4'd0, 16'h1234, 16'h0001, 1'b0, 16'h0000);
        step("andi_sext", 4'b0001, 4'h0, 4'd0, 16'hF0F0, 16'h00FF, 1'b1, 16'hF0F0);
        step("ori", 4'b0010, 4'h0, 4'd0, 16'hF000, 16'h0012, 1'b0, 16'hF012);
        step("movi_sext", 4'b1101, 4'h0, 4'd0, 16'h0000, 16'h0080, 1'b1, 16'hFF80);

        // condition-set and jumps
        step("cmp_eq", 4'b0000, 4'b1011, 4'd0, 16'h0007, 16'h0007, 1'b0, 16'h0000);
        flags_after("cmp_eq_flags", 5'b00010);
        step("scond_z", 4'b0100, 4'b1101, 4'd0, 16'h0000, 16'h0000, 1'b0, 16'h0001);
        step("jcond_nz", 4'b0100, 4'b1100, 4'd1, 16'h1111, 16'h2222, 1'b0, 16'h1111);
        step("cmpi_signed", 4'b1011, 4'h0, 4'd0, 16'hFFFF, 16'h0001, 1'b0, 16'hFFFE);
        flags_after("cmpi_signed_flags", 5'b00001);
        step("jcond_n", 4'b0100, 4'b1100, 4'd6, 16'h1111, 16'h2222, 1'b0, 16'h2222);
        step("pass", 4'b0100, 4'b1000, 4'd0, 16'h1111, 16'h5A5A, 1'b0, 16'h5A5A);

        // asynchronous reset mid-cycle
        step("add_pre_reset", 4'b0000, 4'b0101, 4'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000);
        flags_after("pre_reset_flags", 5'b10001);
        step("scond_c_set", 4'b0100, 4'b1101, 4'd2, 16'h0000, 16'h0000, 1'b0, 16'h0001);
        #2;
        reset = 1'b1;
        #1;
        check("reset_async_flags", {11'b0, c, l, f, z, n}, 16'h0000);
        check("scond_c_reset", result, 16'h0000);
        step("scond_always", 4'b0100, 4'b1101, 4'd14, 16'h0000, 16'h0000, 1'b0, 16'h0001);
        step("add_in_reset", 4'b0000, 4'b0101, 4'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000);
        flags_after("reset_hold_flags", 5'b00000);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- 16-bit integer ALU for the processor datapath.
- Combinational result path computes arithmetic, logic, shift, move, condition-set, branch-target and LUI results from the dst and src operands under control of oper/func/cond.
- A registered processor-status flag set (c, l, f, z, n) is updated at clock edges by flag-setting instructions and feeds carry-in and condition evaluation.

Parameters:
- WIDTH, 16, datapath width; all behaviour below is defined for 16 only.

Ports:
- clk  in  1  system clock; flags update on rising edge.
- reset  in  1  asynchronous, active-high; clears flags.
- dst  in  16  destination/first operand (register value).
- src  in  16  source operand (register value or immediate in src[7:0]).
- oper  in  4  primary opcode.
- func  in  4  extended opcode for oper 0000, 0100 and 1000.
- cond  in  4  condition selector for Scond/Bcond/Jcond.
- sign_ext_imm  in  1  1: immediate operand is {{8{src[7]}},src[7:0]}; 0: src used unmodified.
- result  out  16  combinational result.
- c, l, f, z, n  out  1 each  registered flags: carry/borrow, unsigned-less, signed overflow, zero/equal, signed-less.

Behaviour:
- Operand: S = sign_ext_imm ? sext(src[7:0]) : src for immediate opcodes (oper not in {0000, 0100, 1000}); otherwise S = src.
- oper 0000 by func:
  - 0101 ADD, 0110 ADDU: dst+S.
  - 0111 ADDC: dst+S+c.
  - 1001 SUB, 1011 CMP: dst-S.
  - 1010 SUBC: dst-S-c.
  - 1110 MUL: low 16 bits of dst*S.
  - 0001 AND, 1111 AND: dst&S.
  - 0010 OR: dst|S.
  - 0011 XOR: dst^S.
  - 0100 NOT: ~dst.
  - 1101 MOV: S.
  - Any other func: 0.
- oper 0001/0010/0011: ANDI/ORI/XORI.
- oper 0101/0110/0111: ADDI/ADDUI/ADDCI.
- oper 1001/1010/1011: SUBI/SUBCI/CMPI.
- oper 1101: MOVI = S.
- oper 1110: MULI.
- oper 1111: LUI = {S[7:0]... } defined as {dst[7:0], src[7:0]}, i.e. (dst<<8)|src[7:0].
- oper 0100 by func:
  - 1000 passthrough = src.
  - 1101 Scond = {15'b0, T}.
  - 1100 Jcond = T ? src : dst.
  - Any other func: 0.
- oper 1100: Bcond = T ? dst+S : dst.
- oper 1000 shifts, k = src[4:0]:
  - func 0000 SLL and 0010 SAL: dst << src[3:0].
  - func 0001 SRL: dst >> (-k mod 32), zero fill.
  - func 0011 SAR: same count, fill with dst[15].
  - Counts >= 16 give 0, or all dst[15] for SAR.
  - func 0100 LSH: k[4] ? SRL : SLL.
  - func 0110 ASHU: k[4] ? SAR : SAL.
  - Any other func: 0.
- Condition T by cond:
  - 0 z; 1 !z; 2 c; 3 !c; 4 l; 5 !l; 6 n; 7 !n; 8 f; 9 !f.
  - 10 !l&!z; 11 l|z; 12 !n&!z; 13 n|z.
  - 14 always 1; 15 always 0.
- Flags, registered at rising clk, using current-cycle operands:
  - ADD/ADDI/ADDC/ADDCI: c = carry out of bit 15; f = signed overflow.
  - SUB/SUBI/SUBC/SUBCI: c = borrow (unsigned dst < S + carry-in); f = signed overflow.
  - CMP/CMPI: z = (dst==S); l = dst<S unsigned; n = dst<S signed.
  - All other ops, including ADDU/ADDUI: flags unchanged.
- Reset: asynchronous assertion forces c=l=f=z=n=0 immediately; holds while asserted. result remains combinational and valid during reset, using zeroed flags.
- Latency: result 0 cycles; flag effect visible to the next instruction's ADDC/SUBC/cond.
- Arithmetic wraps modulo 2^16.

Test Plan:
- ADD: oper 0000 func 0101, dst 0xFFFF, src 0x0001 -> result 0x0000; after edge c=1, f=0. Then ADDC with dst 1, src 1 -> result 0x0003.
- CMP then Bcond: dst 5, src 7, oper 1011 -> after edge l=1, n=1, z=0. Bcond oper 1100, cond 4, dst 0x0100, src 0x0010 -> 0x0110; cond 5 -> 0x0100.
- Shifts: dst 0x8000, oper 1000 func 0011, src 0x001F (count 1) -> 0xC000; func 0001 same -> 0x4000; func 0000, src 4, dst 0x0001 -> 0x0010.
- Immediate sign extension: oper 0101, dst 0x0010, src 0x00FF, sign_ext_imm=1 -> 0x000F; sign_ext_imm=0 -> 0x010F.
- LUI/MUL/NOT: oper 1111, dst 0x12AB, src 0x0034 -> 0xAB34; oper 1110, 0x0100*0x0100 -> 0x0000; oper 0000 func 0100, dst 0x00FF -> 0xFF00.
- Reset: set c=1 via ADD overflow, assert reset mid-cycle -> c=l=f=z=n=0 before next edge. Scond cond 2 then returns 0x0000; cond 14 returns 0x0001.
